// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared encodings for the md issue controller (op classes, mdctr codes, FSM states, default TIMEOUT)
package md_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8
  } md_op_e;

  localparam logic [2:0] MDCTR_MULT  = 3'd0;
  localparam logic [2:0] MDCTR_MULTU = 3'd1;
  localparam logic [2:0] MDCTR_DIV   = 3'd2;
  localparam logic [2:0] MDCTR_DIVU  = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } md_state_e;

  localparam int MD_TIMEOUT_DEFAULT = 16;

  // MULT..DIVU are numbered one above their mdctr code
  function automatic logic [2:0] op_to_mdctr(input logic [3:0] op);
    logic [3:0] code;
    code = op - 4'd1;
    return code[2:0];
  endfunction

endpackage

// File: rtl/md_watchdog.sv
// rtl/md_watchdog.sv - busy timeout counter with sticky error, used only when MD_WATCHDOG_EN is defined
module md_watchdog
  import md_pkg::*;
#(
  parameter int TIMEOUT = MD_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expire,
  output logic md_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // this WAIT cycle's busy tick is the one that brings the count to TIMEOUT
  always_comb begin
    expire = tick && (cnt == CW'(TIMEOUT - 1));
  end

  // saturating busy-cycle count, restarted whenever a new op enters WAIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (tick && (cnt != CW'(TIMEOUT))) begin
      cnt <= cnt + 1'b1;
    end
  end

  // error stays set until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      md_err <= 1'b0;
    end else if (expire) begin
      md_err <= 1'b1;
    end
  end

endmodule

// File: rtl/md_issue_ctrl.sv
// rtl/md_issue_ctrl.sv - md hazard stall and multdiv issue control; optional busy watchdog under MD_WATCHDOG_EN
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int TIMEOUT = MD_TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] id_md_op,
  input  logic       hold,
  input  logic       busy,
  output logic       stall_md,
  output logic       start,
  output logic [2:0] mdctr,
  output logic       hiwrite,
  output logic       lowrite,
  output logic       md_err
);

  md_state_e state, state_nxt;
  logic      is_md;
  logic      issue;
  logic      issue_md;
  logic      wd_expire;

  // hazard detection, issue qualification and next state
  always_comb begin
    is_md     = (id_md_op >= OP_MULT) && (id_md_op <= OP_MFLO);
    stall_md  = is_md && ((state != ST_IDLE) || busy);
    issue     = (id_md_op >= OP_MULT) && (id_md_op <= OP_MTLO) && !stall_md && !hold;
    issue_md  = issue && (id_md_op <= OP_DIVU);
    state_nxt = state;
    case (state)
      ST_IDLE:  if (issue_md) state_nxt = ST_ISSUE;
      // busy is not yet visible during ISSUE, so it is never sampled there
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (!busy || wd_expire) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // state register and registered pulses to multdiv / HI / LO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      start   <= 1'b0;
      mdctr   <= MDCTR_MULT;
      hiwrite <= 1'b0;
      lowrite <= 1'b0;
    end else begin
      state   <= state_nxt;
      start   <= issue_md;
      hiwrite <= issue && (id_md_op == OP_MTHI);
      lowrite <= issue && (id_md_op == OP_MTLO);
      if (issue_md) begin
        mdctr <= op_to_mdctr(id_md_op);
      end
    end
  end

`ifdef MD_WATCHDOG_EN
  md_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_md_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == ST_ISSUE),
    .tick   ((state == ST_WAIT) && busy),
    .expire (wd_expire),
    .md_err (md_err)
  );
`else
  assign wd_expire = 1'b0;
  assign md_err    = 1'b0;
`endif

endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb/tb_md_issue_ctrl.sv - self-checking bench for md_issue_ctrl (covers MD_WATCHDOG_EN when defined)
module tb_md_issue_ctrl;
  import md_pkg::*;

`ifdef MD_WATCHDOG_EN
  localparam int TO = 4;
`else
  localparam int TO = 16;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] id_md_op = 4'd0;
  logic       hold = 1'b0;
  logic       busy = 1'b0;
  logic       stall_md;
  logic       start;
  logic [2:0] mdctr;
  logic       hiwrite;
  logic       lowrite;
  logic       md_err;

  int vectors = 0;
  int miscompares = 0;

  md_issue_ctrl #(.TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .id_md_op (id_md_op),
    .hold     (hold),
    .busy     (busy),
    .stall_md (stall_md),
    .start    (start),
    .mdctr    (mdctr),
    .hiwrite  (hiwrite),
    .lowrite  (lowrite),
    .md_err   (md_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: "an op is outstanding" plus expected next-cycle pulses
  bit         m_out;
  bit         m_fresh;
  bit         m_err;
  bit         e_start, e_hi, e_lo;
  logic [2:0] e_mdctr;
  bit         c_md, c_stall, c_iss;
`ifdef MD_WATCHDOG_EN
  int         m_wcnt;
`endif

  always @(negedge clk) begin
    if (rst) begin
      m_out = 0; m_fresh = 0; m_err = 0;
      e_start = 0; e_hi = 0; e_lo = 0; e_mdctr = 3'd0;
`ifdef MD_WATCHDOG_EN
      m_wcnt = 0;
`endif
      chk("rst_start", 32'(start), 0);
      chk("rst_mdctr", 32'(mdctr), 0);
      chk("rst_hiwrite", 32'(hiwrite), 0);
      chk("rst_lowrite", 32'(lowrite), 0);
      chk("rst_md_err", 32'(md_err), 0);
    end else begin
      c_md    = (id_md_op >= 4'd1) && (id_md_op <= 4'd8);
      c_stall = c_md && (m_out || busy);
      chk("stall_md", 32'(stall_md), 32'(c_stall));
      chk("start", 32'(start), 32'(e_start));
      chk("mdctr", 32'(mdctr), 32'(e_mdctr));
      chk("hiwrite", 32'(hiwrite), 32'(e_hi));
      chk("lowrite", 32'(lowrite), 32'(e_lo));
      chk("md_err", 32'(md_err), 32'(m_err));
      chk("pulse_onehot", 32'((32'(start) + 32'(hiwrite) + 32'(lowrite)) <= 1), 1);
      c_iss = (id_md_op >= 4'd1) && (id_md_op <= 4'd6) && !c_stall && !hold;
      if (m_out) begin
        if (m_fresh) m_fresh = 0;
        else begin
`ifdef MD_WATCHDOG_EN
          if (busy) begin
            m_wcnt++;
            if (m_wcnt >= TO) begin m_err = 1; m_out = 0; end
          end
`endif
          if (!busy) m_out = 0;
        end
      end
      e_start = c_iss && (id_md_op <= 4'd4);
      e_hi    = c_iss && (id_md_op == 4'd5);
      e_lo    = c_iss && (id_md_op == 4'd6);
      if (e_start) begin
        e_mdctr = 3'(id_md_op - 4'd1);
        m_out = 1; m_fresh = 1;
`ifdef MD_WATCHDOG_EN
        m_wcnt = 0;
`endif
      end
    end
  end

  task automatic step(input logic [3:0] op, input logic h, input logic b);
    @(posedge clk); #1;
    id_md_op = op; hold = h; busy = b;
    @(negedge clk);
  endtask

  int stall_n;
  int starts;
  int busy_left;

  initial begin
    @(negedge clk);
    chk("reset_stall", 32'(stall_md), 0);
    @(posedge clk); #1; rst = 0;

    // MULT with 5 busy cycles, DIV waiting behind it
    step(OP_MULT, 0, 0); chk("mult_id_stall", 32'(stall_md), 0);
    step(OP_DIV, 0, 0);  chk("mult_start", 32'(start), 1); chk("mult_mdctr", 32'(mdctr), 0);
    stall_n = 32'(stall_md); starts = 32'(start);
    repeat (5) begin step(OP_DIV, 0, 1); stall_n += 32'(stall_md); starts += 32'(start); end
    step(OP_DIV, 0, 0); stall_n += 32'(stall_md); starts += 32'(start);
    step(OP_DIV, 0, 0); chk("div_stall_released", 32'(stall_md), 0);
    chk("div_stall_cycles", 32'(stall_n), 7);
    chk("mult_start_cycles", 32'(starts), 1);
    step(OP_NONE, 0, 0); chk("div_start", 32'(start), 1); chk("div_mdctr", 32'(mdctr), 2);
    step(OP_NONE, 0, 1); step(OP_NONE, 0, 0); step(OP_NONE, 0, 0);
    chk("mdctr_held", 32'(mdctr), 2);

    // MTLO / MTHI pulses
    step(OP_MTLO, 0, 0); chk("mtlo_stall", 32'(stall_md), 0);
    step(OP_NONE, 0, 0); chk("mtlo_lowrite", 32'(lowrite), 1); chk("mtlo_start", 32'(start), 0);
    step(OP_MTHI, 0, 0); chk("mtlo_one_cycle", 32'(lowrite), 0);
    step(OP_NONE, 0, 0); chk("mthi_hiwrite", 32'(hiwrite), 1);

    // MFHI right behind DIVU
    step(OP_DIVU, 0, 0);
    step(OP_MFHI, 0, 0); chk("mfhi_issue_stall", 32'(stall_md), 1); chk("divu_mdctr", 32'(mdctr), 3);
    repeat (3) begin step(OP_MFHI, 0, 1); chk("mfhi_busy_stall", 32'(stall_md), 1); end
    step(OP_MFHI, 0, 0); chk("mfhi_fall_stall", 32'(stall_md), 1);
    step(OP_MFHI, 0, 0); chk("mfhi_released", 32'(stall_md), 0);
    step(OP_NONE, 0, 0); chk("mfhi_no_start", 32'(start), 0); chk("mfhi_no_hi", 32'(hiwrite), 0);

    // DIV held for 3 cycles
    repeat (3) begin step(OP_DIV, 1, 0); chk("held_no_start", 32'(start), 0); end
    step(OP_DIV, 0, 0); chk("unheld_no_start_yet", 32'(start), 0);
    step(OP_NONE, 0, 0); chk("after_hold_start", 32'(start), 1);
    step(OP_NONE, 0, 1); step(OP_NONE, 0, 0); step(OP_NONE, 0, 0);

    // async reset during WAIT
    step(OP_DIVU, 0, 0); step(OP_NONE, 0, 0); step(OP_MFHI, 0, 1);
    chk("wait_stall", 32'(stall_md), 1);
    @(posedge clk); #1; busy = 0; #1;
    chk("wait_stall_busy_low", 32'(stall_md), 1);
    chk("wait_mdctr", 32'(mdctr), 3);
    #1; rst = 1; #1;
    chk("async_rst_stall", 32'(stall_md), 0);
    chk("async_rst_mdctr", 32'(mdctr), 0);
    @(posedge clk); #1; rst = 0;
    step(OP_MULT, 0, 1); chk("post_rst_busy_stall", 32'(stall_md), 1);
    step(OP_MULT, 0, 0); chk("post_rst_free", 32'(stall_md), 0);
    step(OP_NONE, 0, 0); chk("post_rst_start", 32'(start), 1);
    step(OP_NONE, 0, 1); step(OP_NONE, 0, 0); step(OP_NONE, 0, 0);

`ifdef MD_WATCHDOG_EN
    step(OP_MULT, 0, 0); step(OP_NONE, 0, 1);
    repeat (4) begin step(OP_MFHI, 0, 1); chk("wd_not_yet", 32'(md_err), 0); end
    step(OP_MFHI, 0, 1); chk("wd_err_set", 32'(md_err), 1);
    step(OP_MFHI, 0, 0); chk("wd_forced_idle", 32'(stall_md), 0);
    repeat (3) step(OP_NONE, 0, 0);
    chk("wd_sticky", 32'(md_err), 1);
    @(posedge clk); #1; rst = 1; #1;
    chk("wd_rst_clear", 32'(md_err), 0);
    @(posedge clk); #1; rst = 0;
`endif

    // randomized traffic with a responsive multdiv stand-in
    busy_left = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (rst) rst = 0;
      else if ($urandom_range(0, 299) == 0) begin rst = 1; busy_left = 0; end
      id_md_op = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      hold = ($urandom_range(0, 3) == 0);
      if (busy_left > 0) begin busy = 1; busy_left--; end
      else busy = ($urandom_range(0, 19) == 0);
      if (start) busy_left = $urandom_range(1, 6);
    end
    @(posedge clk); #1; rst = 0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/md_issue_ctrl.md
MD_ISSUE_CTRL -- requirements
Module: md_issue_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 16, max cycles busy may stay high before md_err (only with MD_WATCHDOG_EN).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous reset, active-high.
REQ-004 id_md_op  input  4  decoded class of the instruction in ID: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8; values 9-15 are treated as NONE.
REQ-005 hold  input  1  pipeline frozen by another hazard; the ID instruction does not advance.
REQ-006 busy  input  1  busy flag from multdiv.
REQ-007 stall_md  output  1  combinational request to freeze PC/IF/ID because of an md hazard.
REQ-008 start  output  1  registered one-cycle start pulse to multdiv.
REQ-009 mdctr  output  3  registered op select to multdiv: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU; 4-7 never driven.
REQ-010 hiwrite, lowrite  output  1 each  registered one-cycle write pulses for MTHI/MTLO.
REQ-011 md_err  output  1  sticky watchdog error flag.

Function
REQ-012 The block SHALL implement FSM states IDLE, ISSUE and WAIT.
REQ-013 Any md op = any id_md_op value 1-8.
REQ-014 stall_md SHALL be 1 iff an md op is in ID and (state != IDLE or busy == 1).
REQ-015 An op issues when id_md_op is 1-6, stall_md = 0 and hold = 0.
REQ-016 On a MULT/MULTU/DIV/DIVU issue at edge N: start = 1 and mdctr = op code for cycle N+1 only; state moves IDLE -> ISSUE.
REQ-017 ISSUE SHALL always last exactly one cycle, then go to WAIT, covering the cycle before busy rises.
REQ-018 WAIT SHALL go to IDLE on the first edge sampling busy = 0; from release, stall_md drops in the same cycle busy = 0 is seen by IDLE.
REQ-019 MTHI/MTLO issue SHALL pulse hiwrite/lowrite for one cycle, leave state IDLE and assert no start.
REQ-020 MFHI/MFLO SHALL cause no pulses, only stall per REQ-014.
REQ-021 mdctr SHALL hold its last value between issues; start, hiwrite and lowrite SHALL be 0 whenever not pulsing.
REQ-022 hold = 1 in IDLE SHALL suppress issue and every output pulse; hold in ISSUE/WAIT SHALL NOT alter the transitions.
REQ-023 At most one of start, hiwrite, lowrite SHALL be high in any cycle.

Reset
REQ-024 rst = 1 SHALL asynchronously force state = IDLE, start = 0, mdctr = 0, hiwrite = 0, lowrite = 0, md_err = 0 and clear the watchdog counter.
REQ-025 Reset mid-ISSUE/WAIT SHALL abandon the op; after release, ops in ID issue only if busy = 0.

Configuration
REQ-026 Macro MD_WATCHDOG_EN: when defined, a counter clears on entering WAIT and increments each WAIT cycle with busy = 1, saturating.
REQ-027 When the count reaches TIMEOUT, md_err SHALL be set and held until reset, with state forced to IDLE.
REQ-028 Without the macro, md_err SHALL be constant 0, with no counter logic.

Structure
REQ-029 A shared package md_pkg SHALL hold: the id_md_op encodings, mdctr codes, FSM state encoding, and the default TIMEOUT.
REQ-030 The watchdog SHALL be sub-module md_watchdog, instantiated only under MD_WATCHDOG_EN; all else is flat.

Verification
REQ-031 MULT issue with busy high for 5 cycles, then low -> start = 1, mdctr = 0 for exactly 1 cycle.
REQ-032 MULT issue with busy high for 5 cycles, then low -> a following DIV in ID sees stall_md = 1 for 7 cycles, then issues with mdctr = 2.
REQ-033 MTLO in IDLE -> lowrite pulses 1 cycle, start = 0, stall_md = 0.
REQ-034 MFHI directly after DIVU issue -> stall_md = 1 through ISSUE and all busy cycles, 0 the cycle after busy falls.
REQ-035 DIV in ID with hold = 1 for 3 cycles -> no start; start pulses the cycle after hold drops.
REQ-036 rst = 1 during WAIT -> all outputs 0 immediately (no clock); with MD_WATCHDOG_EN, TIMEOUT = 4 and busy stuck high -> md_err = 1 after 4 WAIT cycles, sticky until reset.
